// File: rtl/text_tile_renderer.sv
// rtl/text_tile_renderer.sv - character-cell renderer with tile RAM, clear FSM and blinking cursor
// Pixel coordinates in, 12-bit colour out three cycles later; the glyph ROM sits outside.
module text_tile_renderer #(
   parameter int          COLS         = 160,
   parameter int          ROWS         = 45,
   parameter int          TILE_W       = 8,
   parameter int          TILE_H       = 16,
   parameter int          BLINK_FRAMES = 30,
   parameter logic [7:0]  CLR_CHAR     = 8'h20,
   parameter logic [5:0]  CLR_ATTR     = 6'b111000
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            pix_valid,
   input  logic [15:0]                     pix_x,
   input  logic [15:0]                     pix_y,
   input  logic                            frame_start,
   output logic [8+$clog2(TILE_H)-1:0]     glyph_addr,
   input  logic [TILE_W-1:0]               glyph_row,
   input  logic                            wr_valid,
   output logic                            wr_ready,
   input  logic [7:0]                      wr_col,
   input  logic [7:0]                      wr_row,
   input  logic [7:0]                      wr_char,
   input  logic [5:0]                      wr_attr,
   input  logic                            clr_start,
   output logic                            clr_busy,
   input  logic                            cursor_en,
   input  logic [7:0]                      cursor_col,
   input  logic [7:0]                      cursor_row,
   output logic [11:0]                     color_out,
   output logic                            color_valid
);
   localparam int NT = COLS * ROWS;
   localparam int AW = (NT > 1) ? $clog2(NT) : 1;
   localparam int XS = $clog2(TILE_W);
   localparam int YS = $clog2(TILE_H);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

   typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   clr_cnt_q, clr_cnt_d;
   logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
   logic            blink_phase_q, blink_phase_d;

   logic [13:0]     tile_mem [NT];

   logic [15:0]     col, row;
   logic            in_range, cursor_hit, wr_in_range;
   logic [AW-1:0]   rd_addr, wr_addr;

   logic [13:0]     tile_q;
   logic            v1_q, inr1_q, hit1_q;
   logic [XS-1:0]   subx1_q;
   logic [YS-1:0]   suby1_q;
   logic            v2_q, inr2_q, hit2_q;
   logic [XS-1:0]   subx2_q;
   logic [5:0]      attr2_q;
   logic [11:0]     color_q, color_d;
   logic            cvalid_q;

   logic [XS-1:0]   bit_idx;
   logic            pix_on;
   logic [2:0]      fg, bg, rgb;

   assign col         = pix_x >> XS;
   assign row         = pix_y >> YS;
   assign in_range    = (int'(col) < COLS) && (int'(row) < ROWS);
   // Out-of-range coordinates read address 0 so the RAM index never leaves the array.
   assign rd_addr     = in_range ? AW'(int'(row) * COLS + int'(col)) : '0;
   assign cursor_hit  = cursor_en && blink_phase_q &&
                        (col == {8'd0, cursor_col}) && (row == {8'd0, cursor_row});

   assign wr_ready    = (state_q == IDLE) && !clr_start;
   assign wr_in_range = (int'(wr_col) < COLS) && (int'(wr_row) < ROWS);
   assign wr_addr     = wr_in_range ? AW'(int'(wr_row) * COLS + int'(wr_col)) : '0;
   assign clr_busy    = (state_q == CLEAR);

   always_ff @(posedge clk) begin
      if (state_q == CLEAR)
         tile_mem[clr_cnt_q] <= {CLR_CHAR, CLR_ATTR};
      else if (wr_valid && wr_ready && wr_in_range)
         tile_mem[wr_addr] <= {wr_char, wr_attr};
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      case (state_q)
         IDLE: if (clr_start) begin
            state_d   = CLEAR;
            clr_cnt_d = '0;
         end
         CLEAR: if (clr_cnt_q == AW'(NT - 1)) state_d = IDLE;
                else clr_cnt_d = clr_cnt_q + 1'b1;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (BLINK_FRAMES == 0) begin
         blink_phase_d = 1'b1;
      end else if (frame_start) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d   = blink_cnt_q + 1'b1;
         end
      end
   end

   // Cursor hit swaps fg/bg; blanked pixels are forced to black.
   assign bit_idx = XS'(TILE_W - 1) - subx2_q;
   assign pix_on  = glyph_row[bit_idx];
   assign fg      = hit2_q ? attr2_q[2:0] : attr2_q[5:3];
   assign bg      = hit2_q ? attr2_q[5:3] : attr2_q[2:0];
   assign rgb     = pix_on ? fg : bg;
   assign color_d = (v2_q && inr2_q) ? {{4{rgb[2]}}, {4{rgb[1]}}, {4{rgb[0]}}} : 12'h000;

   assign glyph_addr  = {tile_q[13:6], suby1_q};
   assign color_out   = color_q;
   assign color_valid = cvalid_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         clr_cnt_q     <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b1;
         tile_q        <= '0;
         v1_q          <= 1'b0;
         inr1_q        <= 1'b0;
         hit1_q        <= 1'b0;
         subx1_q       <= '0;
         suby1_q       <= '0;
         v2_q          <= 1'b0;
         inr2_q        <= 1'b0;
         hit2_q        <= 1'b0;
         subx2_q       <= '0;
         attr2_q       <= '0;
         color_q       <= '0;
         cvalid_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         clr_cnt_q     <= clr_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         tile_q        <= tile_mem[rd_addr];
         v1_q          <= pix_valid;
         inr1_q        <= in_range;
         hit1_q        <= cursor_hit;
         subx1_q       <= pix_x[XS-1:0];
         suby1_q       <= pix_y[YS-1:0];
         v2_q          <= v1_q;
         inr2_q        <= inr1_q;
         hit2_q        <= hit1_q;
         subx2_q       <= subx1_q;
         attr2_q       <= tile_q[5:0];
         color_q       <= color_d;
         cvalid_q      <= v2_q;
      end
   end
endmodule

// File: tb/tb_text_tile_renderer.sv
// tb/tb_text_tile_renderer.sv - directed scoreboard bench for text_tile_renderer
// Small 4x2 screen; expected colours come from a shadow tile map and a glyph ROM model.
module tb_text_tile_renderer;
   logic        clk = 1'b0;
   logic        rst;
   logic        pix_valid, frame_start;
   logic [15:0] pix_x, pix_y;
   logic [11:0] glyph_addr;
   logic [7:0]  glyph_row;
   logic        wr_valid, wr_ready;
   logic [7:0]  wr_col, wr_row, wr_char;
   logic [5:0]  wr_attr;
   logic        clr_start, clr_busy;
   logic        cursor_en;
   logic [7:0]  cursor_col, cursor_row;
   logic [11:0] color_out;
   logic        color_valid;

   int          n_chk = 0;
   int          n_fail = 0;
   int          frames = 0;
   int          cnt;
   logic [13:0] shadow [8];
   logic [11:0] exp_q [$];
   logic [2:0]  pv_pipe;

   text_tile_renderer #(
      .COLS(4), .ROWS(2), .TILE_W(8), .TILE_H(16), .BLINK_FRAMES(2),
      .CLR_CHAR(8'h20), .CLR_ATTR(6'b111000)
   ) dut (
      .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
      .frame_start(frame_start), .glyph_addr(glyph_addr), .glyph_row(glyph_row),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_col(wr_col), .wr_row(wr_row),
      .wr_char(wr_char), .wr_attr(wr_attr), .clr_start(clr_start), .clr_busy(clr_busy),
      .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
      .color_out(color_out), .color_valid(color_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom(input logic [11:0] a);
      return a[11:4] ^ {a[3:0], a[3:0]} ^ 8'h3C;
   endfunction

   always @(posedge clk) glyph_row <= rom(glyph_addr);

   function automatic logic [11:0] model(input int x, input int y);
      int col, row;
      logic [13:0] e;
      logic [7:0] g;
      logic b, h;
      logic [2:0] fg, bg, c;
      col = x / 8;
      row = y / 16;
      if (col >= 4 || row >= 2) return 12'h000;
      e  = shadow[row * 4 + col];
      g  = rom({e[13:6], 4'(y % 16)});
      b  = g[7 - (x % 8)];
      h  = cursor_en && (((frames / 2) % 2) == 0) && col == int'(cursor_col) && row == int'(cursor_row);
      fg = h ? e[2:0] : e[5:3];
      bg = h ? e[5:3] : e[2:0];
      c  = b ? fg : bg;
      return {{4{c[2]}}, {4{c[1]}}, {4{c[0]}}};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   always @(posedge clk or posedge rst)
      if (rst) pv_pipe <= 3'b000;
      else     pv_pipe <= {pv_pipe[1:0], pix_valid};

   always @(negedge clk) begin
      if (!rst) begin
         check("color_valid", color_valid, pv_pipe[2]);
         if (pv_pipe[2]) begin
            if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
            else check("color_out", color_out, exp_q.pop_front());
         end else begin
            check("color_blank", color_out, 12'h000);
         end
      end
   end

   task automatic pix(input int x, input int y, input bit v);
      @(negedge clk);
      frame_start = 1'b0;
      pix_x = 16'(x);
      pix_y = 16'(y);
      pix_valid = v;
      if (v) exp_q.push_back(model(x, y));
   endtask

   task automatic pix_ga(input int x, input int y, input logic [11:0] ga);
      pix(x, y, 1'b1);
      @(negedge clk);
      pix_valid = 1'b0;
      check("glyph_addr", glyph_addr, ga);
   endtask

   task automatic frame();
      @(negedge clk);
      pix_valid = 1'b0;
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      frames++;
   endtask

   task automatic wr(input int c, input int r, input logic [7:0] ch, input logic [5:0] at);
      bit done;
      done = 1'b0;
      @(negedge clk);
      pix_valid = 1'b0;
      wr_col = 8'(c); wr_row = 8'(r); wr_char = ch; wr_attr = at;
      wr_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         #1;
         if (wr_ready) begin
            @(posedge clk);
            if (c < 4 && r < 2) shadow[r * 4 + c] = {ch, at};
            done = 1'b1;
         end
         @(negedge clk);
      end
      wr_valid = 1'b0;
      if (!done) check("wr_timeout", 0, 1);
   endtask

   task automatic clear_all();
      for (int i = 0; i < 8; i++) shadow[i] = {8'h20, 6'b111000};
   endtask

   task automatic wait_busy(input string tag);
      cnt = 0;
      while (clr_busy && cnt < 100) begin
         check({tag, "_wr_ready"}, wr_ready, 1'b0);
         cnt++;
         @(negedge clk);
      end
      check({tag, "_cycles"}, cnt, 8);
      clear_all();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; pix_valid = 1'b0; pix_x = '0; pix_y = '0; frame_start = 1'b0;
      wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_char = '0; wr_attr = '0;
      clr_start = 1'b0; cursor_en = 1'b0; cursor_col = 8'd2; cursor_row = 8'd1;
      repeat (3) @(negedge clk);
      check("rst_color_out", color_out, 12'h000);
      check("rst_color_valid", color_valid, 1'b0);
      check("rst_clr_busy", clr_busy, 1'b0);
      check("rst_wr_ready", wr_ready, 1'b1);
      check("rst_glyph_addr", glyph_addr, 12'h000);
      rst = 1'b0;

      // Clear: 8 busy cycles, then every tile holds the clear character
      @(negedge clk);
      clr_start = 1'b1;
      #1 check("clr_start_blocks_wr", wr_ready, 1'b0);
      @(negedge clk);
      clr_start = 1'b0;
      wait_busy("clear1");
      for (int t = 0; t < 8; t++) pix_ga((t % 4) * 8 + 3, (t / 4) * 16 + 5, {8'h20, 4'd5});

      // 'A' at (2,1), full-tile sweep plus glyph address checks
      wr(2, 1, 8'h41, 6'b111000);
      wr(5, 0, 8'h55, 6'b010001);
      for (int y = 16; y < 32; y++)
         for (int x = 16; x < 24; x++) pix(x, y, 1'b1);
      pix(0, 0, 1'b0);
      pix_ga(17, 16, {8'h41, 4'd0});
      pix_ga(22, 23, {8'h41, 4'd7});
      pix_ga(16, 31, {8'h41, 4'd15});
      pix_ga(9, 20, {8'h20, 4'd4});

      // Out-of-range and invalid pixels
      pix(32, 16, 1'b1);
      pix(16, 32, 1'b1);
      pix(18, 18, 1'b0);
      pix(20, 20, 1'b1);
      pix(0, 0, 1'b0);

      // Blinking cursor at (2,1)
      cursor_en = 1'b1;
      for (int f = 0; f < 6; f++) begin
         for (int x = 8; x < 24; x++) pix(x, 20, 1'b1);
         pix(0, 0, 1'b0);
         frame();
      end
      cursor_en = 1'b0;
      for (int f = 0; f < 2; f++) begin
         for (int x = 16; x < 24; x++) pix(x, 25, 1'b1);
         pix(0, 0, 1'b0);
         frame();
      end

      // Write arriving during a clear is held until the clear finishes
      @(negedge clk);
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      wr_col = 8'd3; wr_row = 8'd0; wr_char = 8'h7E; wr_attr = 6'b100011;
      wr_valid = 1'b1;
      cnt = 0;
      #1;
      while (!wr_ready && cnt < 100) begin
         cnt++;
         @(negedge clk);
         #1;
      end
      check("held_write_wait", cnt, 8);
      @(posedge clk);
      clear_all();
      shadow[3] = {8'h7E, 6'b100011};
      @(negedge clk);
      wr_valid = 1'b0;
      pix_ga(24 + 2, 9, {8'h7E, 4'd9});
      for (int x = 24; x < 32; x++) pix(x, 3, 1'b1);
      pix_ga(17, 16, {8'h20, 4'd0});

      // clr_start and wr_valid together: the clear wins
      @(negedge clk);
      clr_start = 1'b1;
      wr_col = 8'd1; wr_row = 8'd0; wr_char = 8'h5A; wr_attr = 6'b001110;
      wr_valid = 1'b1;
      #1 check("collision_wr_ready", wr_ready, 1'b0);
      @(negedge clk);
      clr_start = 1'b0;
      wr_valid = 1'b0;
      wait_busy("clear2");
      pix_ga(8 + 4, 2, {8'h20, 4'd2});
      pix_ga(24 + 4, 2, {8'h20, 4'd2});

      // Reset mid-clear
      @(negedge clk);
      clr_start = 1'b1;
      @(negedge clk);
      clr_start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midclr_clr_busy", clr_busy, 1'b0);
      check("midclr_wr_ready", wr_ready, 1'b1);
      frames = 0;
      @(negedge clk);
      rst = 1'b0;
      wr(2, 1, 8'h42, 6'b010001);
      pix_ga(19, 18, {8'h42, 4'd2});
      for (int x = 16; x < 24; x++) pix(x, 18, 1'b1);
      pix(0, 0, 1'b0);
      repeat (5) @(negedge clk);
      check("sb_drain", exp_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/text_tile_renderer.md
Name: text_tile_renderer

Overview:
- Parametrised character-cell renderer for the VGA text display.
- Holds an internal dual-port tile RAM of {char, colour attribute} entries, sized by COLS x ROWS.
- Turns a pixel-coordinate stream from vga_core into 12-bit colour with a fixed 3-cycle latency, using an external synchronous glyph ROM.
- Adds per-tile fg/bg colour, a valid/ready write port, a hardware clear-screen FSM and a blinking inverse-video cursor.

Parameters:
- COLS, 160, character columns.
- ROWS, 45, character rows.
- TILE_W, 8, glyph width in pixels (power of 2, max 8).
- TILE_H, 16, glyph height in pixels (power of 2).
- BLINK_FRAMES, 30, frames per cursor blink half-period; 0 = steady cursor.
- CLR_CHAR, 8'h20, character written by clear.
- CLR_ATTR, 6'b111000, attribute written by clear (white on black).

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- pix_valid  in  1  pixel coordinate valid (active video)
- pix_x  in  16  pixel x coordinate
- pix_y  in  16  pixel y coordinate
- frame_start  in  1  one-cycle pulse per frame
- glyph_addr  out  8+log2(TILE_H)  {char, glyph row} to glyph ROM
- glyph_row  in  TILE_W  glyph ROM data, 1-cycle synchronous read; MSB = leftmost pixel
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid && wr_ready
- wr_col  in  8  target column
- wr_row  in  8  target row
- wr_char  in  8  character code
- wr_attr  in  6  {fg_rgb[2:0], bg_rgb[2:0]}
- clr_start  in  1  clear-screen request pulse
- clr_busy  out  1  clear in progress
- cursor_en  in  1  cursor display enable
- cursor_col  in  8  cursor column
- cursor_row  in  8  cursor row
- color_out  out  12  {R4,G4,B4}
- color_valid  out  1  pix_valid delayed 3 cycles

Behaviour:
- Reset values:
  - color_out=0, color_valid=0, clr_busy=0, wr_ready=1, glyph_addr=0.
  - FSM=IDLE, blink counter=0, blink phase=1 (visible).
  - Tile RAM contents are not reset.
- Tile address = row*COLS + col, width clog2(COLS*ROWS).
  - col = pix_x / TILE_W, row = pix_y / TILE_H, computed by shift.
  - sub_x and sub_y are the low bits of pix_x and pix_y.
- Pipeline:
  - C0: coords registered, tile RAM port B read issued.
  - C1: {char, attr} available; glyph_addr = {char, sub_y} driven, registered.
  - C2: glyph_row valid.
  - C3: color_out and color_valid registered.
  - Latency is exactly 3 for every pixel. sub_x, attr and the cursor hit are delayed alongside.
- Pixel colour:
  - bit = glyph_row[TILE_W-1-sub_x]; colour = bit ? fg : bg.
  - Each rgb bit expands to 4'hF or 4'h0.
- Cursor hit = cursor_en && blink_phase && col==cursor_col && row==cursor_row. On a hit, fg and bg are swapped.
- Out of range: col>=COLS, row>=ROWS, or pix_valid=0 forces color_out=0. The RAM read is still harmless.
- Write port (port A):
  - wr_ready = (FSM==IDLE).
  - An accepted write updates the tile in the same cycle.
  - A write with col>=COLS or row>=ROWS is accepted and dropped.
  - Display reads of the same address in the same cycle may return old data.
- Clear FSM, IDLE -> CLEAR:
  - Entered on clr_start in IDLE.
  - Writes {CLR_CHAR, CLR_ATTR} to addresses 0..COLS*ROWS-1, one per cycle.
  - Returns to IDLE the cycle after the last address.
  - clr_busy = (FSM==CLEAR); duration is exactly COLS*ROWS cycles.
  - clr_start while busy is ignored.
  - clr_start together with wr_valid in IDLE: the clear wins and the write is not accepted (wr_ready goes low only from the next cycle, so the handshake must treat this case explicitly: wr_ready=0 when clr_start=1).
- Blink:
  - On frame_start the counter increments.
  - At BLINK_FRAMES-1 the counter wraps to 0 and blink_phase toggles.
  - With BLINK_FRAMES=0, blink_phase is held at 1.
- Reset mid-clear: FSM returns to IDLE immediately; the RAM is partially cleared.

Test Plan:
- Write (col 2, row 1, 'A'=8'h41, attr 111000); drive pix (x=16..23, y=16..31) with the ROM model -> glyph_addr={8'h41, sub_y} one cycle after C0; color_out=12'hFFF on set bits, 12'h000 elsewhere; exactly 3-cycle latency.
- COLS=4, ROWS=2, clr_start -> clr_busy high for 8 cycles, wr_ready=0 throughout; every tile reads back as 8'h20; a wr_valid during clear is held until wr_ready returns.
- Cursor at (2,1), cursor_en=1, BLINK_FRAMES=2 -> that tile is inverted (bg 12'hFFF, fg 12'h000) for 2 frames, normal for 2 frames, repeating; cursor_en=0 -> never inverted.
- pix_x=COLS*TILE_W (out of range) or pix_valid=0 -> color_out=0; color_valid follows pix_valid delayed 3 cycles.
- Assert rst midway through a clear -> clr_busy=0 and wr_ready=1 asynchronously; a subsequent write succeeds.
- clr_start and wr_valid in the same IDLE cycle -> the write is not accepted; the clear runs to completion.
